// File: rtl/pic_8259_pkg.sv
// Shared definitions for the 8259 in-service / acknowledge logic:
// OCW2 command codes, acknowledge FSM states and level helper functions.
package pic_8259_pkg;

   // OCW2 {R, SL, EOI} command codes
   localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_NOP          = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
   localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ACK1 = 3'd1,
      ST_ACK2 = 3'd2,
      ST_ACK3 = 3'd3,
      ST_END  = 3'd4
   } ack_state_t;

   function automatic logic [2:0] encode_level(input logic [7:0] onehot);
      logic [2:0] res;
      res = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (onehot[i]) res = res | 3'(i);
      end
      return res;
   endfunction

   // Scan upward from the level just above 'lowest', wrapping, and return the
   // first set bit as a one-hot vector (0 when nothing is set).
   function automatic logic [7:0] first_set_rotated(input logic [7:0] bits,
                                                    input logic [2:0] lowest);
      logic [7:0] res;
      logic       found;
      logic [2:0] lvl;
      res   = 8'h00;
      found = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         lvl = lowest + 3'(i);
         if (!found && bits[lvl]) begin
            res[lvl] = 1'b1;
            found    = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ack_sequencer_8259.sv
// INTA edge detector and acknowledge-cycle FSM; reports pulse index and
// the enter-ACK1 / END strobes to the in-service logic.
module ack_sequencer_8259
   import pic_8259_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       init_pulse,
   input  logic       inta_n,
   input  logic       u8086_mode,
   output logic [1:0] inta_index,
   output logic       enter_ack1,
   output logic       in_end
);

   logic       inta_cur_q, inta_cur_d;
   logic       inta_prev_q, inta_prev_d;
   ack_state_t state_q, state_d;
   logic       fall_edge, rise_edge;

   assign fall_edge = inta_prev_q & ~inta_cur_q;
   assign rise_edge = ~inta_prev_q & inta_cur_q;

   always_comb begin
      inta_cur_d  = inta_n;
      inta_prev_d = inta_cur_q;
      state_d     = state_q;
      case (state_q)
         ST_IDLE: if (fall_edge) state_d = ST_ACK1;
         ST_ACK1: if (fall_edge) state_d = ST_ACK2;
         ST_ACK2: begin
            if (!u8086_mode && fall_edge)     state_d = ST_ACK3;
            else if (u8086_mode && rise_edge) state_d = ST_END;
         end
         ST_ACK3: if (rise_edge) state_d = ST_END;
         default: state_d = ST_IDLE;
      endcase
   end

   // The INTA history is only cleared by a hard reset, not by ICW1.
   always_ff @(posedge clk) begin
      if (reset) begin
         inta_cur_q  <= 1'b1;
         inta_prev_q <= 1'b1;
      end else begin
         inta_cur_q  <= inta_cur_d;
         inta_prev_q <= inta_prev_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || init_pulse) state_q <= ST_IDLE;
      else                     state_q <= state_d;
   end

   always_comb begin
      case (state_q)
         ST_ACK1: inta_index = 2'd1;
         ST_ACK2: inta_index = 2'd2;
         ST_ACK3: inta_index = 2'd3;
         default: inta_index = 2'd0;
      endcase
   end

   assign enter_ack1 = (state_q == ST_IDLE) && fall_edge;
   assign in_end     = (state_q == ST_END);

endmodule

// File: rtl/isr_8259.sv
// 8259 in-service register, rotation state, EOI/AEOI handling and CPU INT
// generation, downstream of the priority resolver.
module isr_8259
   import pic_8259_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] interrupt,
   input  logic       inta_n,
   input  logic       u8086_mode,
   input  logic       auto_eoi_config,
   input  logic       init_pulse,
   input  logic       ocw2_write,
   input  logic [2:0] ocw2_cmd,
   input  logic [2:0] ocw2_level,
   output logic       interrupt_to_cpu,
   output logic [7:0] in_service_register,
   output logic [7:0] highest_level_in_service,
   output logic [2:0] priority_rotate,
   output logic [7:0] clear_interrupt_request,
   output logic [2:0] ack_level,
   output logic [1:0] inta_index,
   output logic       end_of_acknowledge
);

   logic       enter_ack1, in_end;
   logic       int_q, int_d;
   logic [7:0] isr_q, isr_d;
   logic [2:0] rot_q, rot_d;
   logic       rot_aeoi_q, rot_aeoi_d;
   logic [2:0] ack_level_q, ack_level_d;
   logic       spurious_q, spurious_d;
   logic [7:0] clr_req_q, clr_req_d;
   logic [7:0] isr_set, isr_clr;
   logic [7:0] hlis;

   ack_sequencer_8259 u_seq (
      .clk        (clk),
      .reset      (reset),
      .init_pulse (init_pulse),
      .inta_n     (inta_n),
      .u8086_mode (u8086_mode),
      .inta_index (inta_index),
      .enter_ack1 (enter_ack1),
      .in_end     (in_end)
   );

   assign hlis = first_set_rotated(isr_q, rot_q);

   always_comb begin
      int_d       = int_q;
      rot_d       = rot_q;
      rot_aeoi_d  = rot_aeoi_q;
      ack_level_d = ack_level_q;
      spurious_d  = spurious_q;
      clr_req_d   = 8'h00;
      isr_set     = 8'h00;
      isr_clr     = 8'h00;

      if (enter_ack1) begin
         int_d = 1'b0;
         if (interrupt != 8'h00) begin
            isr_set     = interrupt;
            clr_req_d   = interrupt;
            ack_level_d = encode_level(interrupt);
            spurious_d  = 1'b0;
         end else begin
            ack_level_d = 3'd7;
            spurious_d  = 1'b1;
         end
      end else if (in_end && auto_eoi_config && !spurious_q) begin
         isr_clr = 8'b1 << ack_level_q;
         if (rot_aeoi_q) rot_d = ack_level_q;
      end

      if (!enter_ack1 && int_q == 1'b0 && inta_index == 2'd0 && !in_end
          && interrupt != 8'h00)
         int_d = 1'b1;

      // Non-specific EOIs pick their level from the ISR before this cycle's update.
      if (ocw2_write) begin
         case (ocw2_cmd)
            OCW2_NS_EOI:       isr_clr = isr_clr | hlis;
            OCW2_SP_EOI:       isr_clr = isr_clr | (8'b1 << ocw2_level);
            OCW2_ROT_NS_EOI: begin
               if (hlis != 8'h00) begin
                  isr_clr = isr_clr | hlis;
                  rot_d   = encode_level(hlis);
               end
            end
            OCW2_ROT_SP_EOI: begin
               isr_clr = isr_clr | (8'b1 << ocw2_level);
               rot_d   = ocw2_level;
            end
            OCW2_ROT_AEOI_SET: rot_aeoi_d = 1'b1;
            OCW2_ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
            OCW2_SET_PRI:      rot_d      = ocw2_level;
            default:           rot_d      = rot_d;
         endcase
      end

      isr_d = (isr_q & ~isr_clr) | isr_set;
   end

   always_ff @(posedge clk) begin
      if (reset || init_pulse) begin
         int_q       <= 1'b0;
         isr_q       <= 8'h00;
         rot_q       <= 3'd7;
         rot_aeoi_q  <= 1'b0;
         ack_level_q <= 3'd0;
         spurious_q  <= 1'b0;
         clr_req_q   <= 8'h00;
      end else begin
         int_q       <= int_d;
         isr_q       <= isr_d;
         rot_q       <= rot_d;
         rot_aeoi_q  <= rot_aeoi_d;
         ack_level_q <= ack_level_d;
         spurious_q  <= spurious_d;
         clr_req_q   <= clr_req_d;
      end
   end

   assign interrupt_to_cpu         = int_q;
   assign in_service_register      = isr_q;
   assign highest_level_in_service = hlis;
   assign priority_rotate          = rot_q;
   assign clear_interrupt_request  = clr_req_q;
   assign ack_level                = ack_level_q;
   assign end_of_acknowledge       = in_end;

endmodule

// File: tb/tb_isr_8259.sv
// Directed bench for isr_8259: acknowledge sequences, EOI/rotation and reset.
module tb_isr_8259;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] interrupt;
   logic       inta_n;
   logic       u8086_mode;
   logic       auto_eoi_config;
   logic       init_pulse;
   logic       ocw2_write;
   logic [2:0] ocw2_cmd;
   logic [2:0] ocw2_level;
   logic       interrupt_to_cpu;
   logic [7:0] in_service_register;
   logic [7:0] highest_level_in_service;
   logic [2:0] priority_rotate;
   logic [7:0] clear_interrupt_request;
   logic [2:0] ack_level;
   logic [1:0] inta_index;
   logic       end_of_acknowledge;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   isr_8259 dut (
      .clk                      (clk),
      .reset                    (reset),
      .interrupt                (interrupt),
      .inta_n                   (inta_n),
      .u8086_mode               (u8086_mode),
      .auto_eoi_config          (auto_eoi_config),
      .init_pulse               (init_pulse),
      .ocw2_write               (ocw2_write),
      .ocw2_cmd                 (ocw2_cmd),
      .ocw2_level               (ocw2_level),
      .interrupt_to_cpu         (interrupt_to_cpu),
      .in_service_register      (in_service_register),
      .highest_level_in_service (highest_level_in_service),
      .priority_rotate          (priority_rotate),
      .clear_interrupt_request  (clear_interrupt_request),
      .ack_level                (ack_level),
      .inta_index               (inta_index),
      .end_of_acknowledge       (end_of_acknowledge)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Two cycles: one to register inta_n, one for the FSM to act on the edge.
   task automatic inta_fall;
      inta_n = 1'b0;
      tick();
      tick();
   endtask

   task automatic inta_rise;
      inta_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
      ocw2_write = 1'b1;
      ocw2_cmd   = cmd;
      ocw2_level = lvl;
      tick();
      ocw2_write = 1'b0;
   endtask

   task automatic ack_8086(input logic [7:0] irq);
      interrupt = irq;
      tick();
      inta_fall();
      interrupt = 8'h00;
      inta_rise();
      inta_fall();
      inta_rise();
      tick();
   endtask

   initial begin
      reset = 1'b1; interrupt = 8'h00; inta_n = 1'b1; u8086_mode = 1'b1;
      auto_eoi_config = 1'b0; init_pulse = 1'b0; ocw2_write = 1'b0;
      ocw2_cmd = 3'b010; ocw2_level = 3'd0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_int", 8'(interrupt_to_cpu), 8'h00);
      chk("rst_isr", in_service_register, 8'h00);
      chk("rst_rot", 8'(priority_rotate), 8'h07);
      chk("rst_idx", 8'(inta_index), 8'h00);

      // 8086 single request on IR2
      interrupt = 8'h04;
      tick();
      chk("m86_int_set", 8'(interrupt_to_cpu), 8'h01);
      inta_fall();
      chk("m86_int_clr", 8'(interrupt_to_cpu), 8'h00);
      chk("m86_isr", in_service_register, 8'h04);
      chk("m86_ack_level", 8'(ack_level), 8'h02);
      chk("m86_clr_req", clear_interrupt_request, 8'h04);
      chk("m86_idx1", 8'(inta_index), 8'h01);
      interrupt = 8'h00;
      tick();
      chk("m86_clr_req_gone", clear_interrupt_request, 8'h00);
      inta_rise();
      inta_fall();
      chk("m86_idx2", 8'(inta_index), 8'h02);
      inta_rise();
      chk("m86_eoa", 8'(end_of_acknowledge), 8'h01);
      chk("m86_idx_end", 8'(inta_index), 8'h00);
      tick();
      chk("m86_eoa_gone", 8'(end_of_acknowledge), 8'h00);
      chk("m86_isr_kept", in_service_register, 8'h04);
      ocw2(3'b001, 3'd0);
      chk("ns_eoi_isr", in_service_register, 8'h00);

      // spurious acknowledge
      inta_fall();
      chk("sp_ack_level", 8'(ack_level), 8'h07);
      chk("sp_isr", in_service_register, 8'h00);
      chk("sp_clr_req", clear_interrupt_request, 8'h00);
      inta_rise(); inta_fall(); inta_rise();
      chk("sp_eoa", 8'(end_of_acknowledge), 8'h01);
      tick();

      // 8080 three-pulse sequence on IR7
      u8086_mode = 1'b0;
      interrupt = 8'h80;
      tick();
      inta_fall();
      chk("m80_idx1", 8'(inta_index), 8'h01);
      chk("m80_ack_level", 8'(ack_level), 8'h07);
      interrupt = 8'h00;
      inta_rise(); inta_fall();
      chk("m80_idx2", 8'(inta_index), 8'h02);
      inta_rise();
      chk("m80_no_end_yet", 8'(end_of_acknowledge), 8'h00);
      inta_fall();
      chk("m80_idx3", 8'(inta_index), 8'h03);
      inta_rise();
      chk("m80_eoa", 8'(end_of_acknowledge), 8'h01);
      tick();
      chk("m80_isr", in_service_register, 8'h80);
      ocw2(3'b011, 3'd7);
      chk("sp_eoi_isr", in_service_register, 8'h00);
      u8086_mode = 1'b1;

      // rotating non-specific EOI
      ack_8086(8'h02);
      ack_8086(8'h20);
      chk("rot_isr", in_service_register, 8'h22);
      chk("rot_hlis", highest_level_in_service, 8'h02);
      ocw2(3'b101, 3'd0);
      chk("rot1_isr", in_service_register, 8'h20);
      chk("rot1_rot", 8'(priority_rotate), 8'h01);
      chk("rot1_hlis", highest_level_in_service, 8'h20);
      ocw2(3'b101, 3'd0);
      chk("rot2_isr", in_service_register, 8'h00);
      chk("rot2_rot", 8'(priority_rotate), 8'h05);
      ocw2(3'b101, 3'd0);
      chk("rot_empty_noop", 8'(priority_rotate), 8'h05);
      ocw2(3'b110, 3'd7);
      chk("set_pri", 8'(priority_rotate), 8'h07);

      // AEOI with rotation on IR3
      auto_eoi_config = 1'b1;
      ocw2(3'b100, 3'd0);
      ack_8086(8'h08);
      chk("aeoi_isr", in_service_register, 8'h00);
      chk("aeoi_rot", 8'(priority_rotate), 8'h03);
      ocw2(3'b000, 3'd0);
      auto_eoi_config = 1'b0;
      ocw2(3'b110, 3'd7);

      // reset in ACK2 with ISR=01
      interrupt = 8'h01;
      tick();
      inta_fall();
      interrupt = 8'h00;
      inta_rise(); inta_fall();
      chk("mid_idx2", 8'(inta_index), 8'h02);
      chk("mid_isr", in_service_register, 8'h01);
      reset = 1'b1; inta_n = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_isr", in_service_register, 8'h00);
      chk("mid_rst_idx", 8'(inta_index), 8'h00);
      chk("mid_rst_rot", 8'(priority_rotate), 8'h07);
      chk("mid_rst_ack", 8'(ack_level), 8'h00);
      chk("mid_rst_int", 8'(interrupt_to_cpu), 8'h00);
      interrupt = 8'h04;
      tick();
      inta_fall();
      chk("mid_new_idx1", 8'(inta_index), 8'h01);
      chk("mid_new_isr", in_service_register, 8'h04);
      interrupt = 8'h00;
      inta_rise(); inta_fall(); inta_rise(); tick();

      // ICW1 clears in-service state
      init_pulse = 1'b1;
      tick();
      init_pulse = 1'b0;
      chk("init_isr", in_service_register, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/isr_8259.md
# isr_8259

In-service and acknowledge controller for the 8259 PIC. Sits directly downstream of the priority resolver `pr_8259`. Consumes its one-hot `interrupt` winner, drives the CPU INT line, and sequences the INTA pulses. It owns the in-service register, the rotation state and EOI/AEOI handling, and feeds `in_service_register`, `highest_level_in_service` and `priority_rotate` back to the resolver.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `interrupt` in 8: one-hot winning request from the resolver; 0 means none.
- `inta_n` in 1: CPU acknowledge strobe, already synchronised to `clk`, active low.
- `u8086_mode` in 1: 1 selects a 2-pulse INTA sequence; 0 selects the 8080 3-pulse sequence.
- `auto_eoi_config` in 1: AEOI enable.
- `init_pulse` in 1: ICW1 write strobe, one cycle wide.
- `ocw2_write` in 1: OCW2 write strobe, one cycle wide.
- `ocw2_cmd` in 3: {R, SL, EOI} bits.
- `ocw2_level` in 3: L2..L0.
- `interrupt_to_cpu` out 1: INT; registered.
- `in_service_register` out 8: registered ISR.
- `highest_level_in_service` out 8: one-hot highest-priority ISR bit under the current rotation, or 0; combinational.
- `priority_rotate` out 3: lowest-priority level; 7 means IR0 is highest.
- `clear_interrupt_request` out 8: one-cycle one-hot pulse to the IRR.
- `ack_level` out 3: level being acknowledged; registered.
- `inta_index` out 2: current INTA pulse (0 idle, 1..3), used by the data-bus driver.
- `end_of_acknowledge` out 1: one-cycle pulse.

## Operation
- Edge detection: `inta_n` is registered. A falling edge is prev=1 and cur=0. A rising edge is prev=0 and cur=1.
- FSM states:
  - IDLE: a falling edge moves to ACK1.
  - ACK1: a falling edge moves to ACK2.
  - ACK2: in 8080 mode, a falling edge moves to ACK3. In 8086 mode, a rising edge moves to END.
  - ACK3: a rising edge moves to END.
  - END: unconditionally returns to IDLE after one cycle.
- `inta_index` = 1, 2, 3 in ACK1, ACK2, ACK3; 0 otherwise.
- INT is set in IDLE when `interrupt != 0` and cleared on the falling edge that enters ACK1.
- On entering ACK1:
  - If `interrupt != 0`: ISR |= `interrupt`; `ack_level` = encode(`interrupt`); `clear_interrupt_request` = `interrupt` for one cycle.
  - If `interrupt == 0` (spurious): `ack_level` = 7; ISR is unchanged; no clear pulse.
- In END:
  - `end_of_acknowledge` pulses for one cycle.
  - If AEOI is enabled and the cycle was not spurious, ISR bit `ack_level` is cleared.
  - If `rotate_in_aeoi` is also set, `priority_rotate` = `ack_level`.
- OCW2 decode, by {R, SL, EOI}:
  - 001: non-specific EOI; clear the `highest_level_in_service` bit.
  - 011: specific EOI; clear bit `ocw2_level`.
  - 101: as 001, and `priority_rotate` = the cleared level.
  - 111: as 011, and `priority_rotate` = `ocw2_level`.
  - 100: set `rotate_in_aeoi`.
  - 000: clear `rotate_in_aeoi`.
  - 110: `priority_rotate` = `ocw2_level`.
  - 010: no operation.
- A non-specific EOI with ISR = 0 is a no-op, including any rotation.
- `highest_level_in_service` scans from level (`priority_rotate`+1) mod 8 upward with wrap and selects the first set ISR bit.
- `init_pulse` has the same effect as `reset` on all state except the `inta_n` history register.

## Timing
- Reset values: `interrupt_to_cpu` 0, ISR 0, `priority_rotate` 7, `rotate_in_aeoi` 0, `ack_level` 0, `inta_index` 0, `clear_interrupt_request` 0, `end_of_acknowledge` 0, state IDLE.
- Latency:
  - INT rises 1 cycle after `interrupt` becomes nonzero in IDLE.
  - ISR, `ack_level` and the clear pulse update 1 cycle after the sampled falling edge, which is 2 cycles after `inta_n` falls.
- Simultaneous events:
  - An OCW2 EOI in the same cycle as ISR set or AEOI: ISR_next = (ISR & ~clr) | set.
  - A non-specific EOI selects its bit from the pre-update ISR.
  - `init_pulse` or `reset` take priority over everything.
- Reset mid-sequence: returns to IDLE. Later INTA pulses start a new sequence at ACK1.
- After END, INT may re-assert on the next cycle in IDLE.

## Structure
- Shared package `pic_8259_pkg`:
  - OCW2 command constants (`OCW2_NS_EOI`, `OCW2_SP_EOI`, …).
  - FSM state enum.
  - Functions `encode_level` (one-hot to 3-bit) and `first_set_rotated`.
- Sub-module `ack_sequencer_8259`: holds the INTA edge detector and FSM and outputs `inta_index`, enter-ACK1 and END strobes. The ISR and rotation registers stay in the top.

## Test plan
- Single-request acknowledge, 8086 mode:
  - Stimulus: `interrupt`=8'h04, then two INTA pulses.
  - Required: INT=1 then cleared at the first edge; ISR=8'h04; `ack_level`=2; `clear_interrupt_request`=8'h04 for one cycle; `inta_index` steps 1, 2; one `end_of_acknowledge` pulse.
- 8080 mode:
  - Stimulus: `u8086_mode`=0, `interrupt`=8'h80, three INTA pulses.
  - Required: `inta_index` steps 1, 2, 3; END follows only the third rising edge.
- Spurious acknowledge:
  - Stimulus: `interrupt`=0 and an INTA sequence.
  - Required: `ack_level`=7; ISR stays 0; no clear pulse.
- Rotating non-specific EOI:
  - Stimulus: ISR=8'h22 with `priority_rotate`=7, then OCW2 101.
  - Required: ISR=8'h20 and `priority_rotate`=1. A following non-specific EOI clears bit 5 and sets `priority_rotate`=5.
- AEOI with rotate:
  - Stimulus: `auto_eoi_config`=1, OCW2 100, acknowledge IR3.
  - Required: ISR returns to 0 in END and `priority_rotate`=3.
- Reset mid-sequence:
  - Stimulus: `reset` asserted in ACK2 with ISR=8'h01.
  - Required: all outputs return to reset values and the next INTA sequence starts at ACK1.
